// File: rtl/seg_display_driver.sv
// Converts an 8-bit binary count to BCD with a sequential double-dabble engine
// and time-multiplexes hundreds/tens/ones onto a 4-digit common-anode display.
module seg_display_driver #(
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] count,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REF_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t        state;
  logic [19:0]   shift_reg;
  logic [19:0]   adj;
  logic [7:0]    last_val;
  logic [2:0]    iter;
  logic [3:0]    bcd_h, bcd_t, bcd_o;
  logic [CW-1:0] ref_cnt;
  logic [1:0]    digit, digit_next;
  logic          blank_h, blank_t;
  logic [6:0]    seg_next;
  logic [3:0]    an_next;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Add-3 correction on the BCD nibbles before each shift.
  always_comb begin
    // NOTE: start from a full default so every path assigns adj and no latch is inferred.
    adj = shift_reg;
    if (adj[11:8]  >= 4'd5) adj[11:8]  = adj[11:8]  + 4'd3;
    if (adj[15:12] >= 4'd5) adj[15:12] = adj[15:12] + 4'd3;
    if (adj[19:16] >= 4'd5) adj[19:16] = adj[19:16] + 4'd3;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      last_val  <= '0;
      iter      <= '0;
      bcd_h     <= '0;
      bcd_t     <= '0;
      bcd_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != last_val) begin
            shift_reg <= {12'd0, count};
            last_val  <= count;
            iter      <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= adj << 1;
          iter      <= iter + 3'd1;
          if (iter == 3'd7) state <= LOAD;
        end
        LOAD: begin
          bcd_h <= shift_reg[19:16];
          bcd_t <= shift_reg[15:12];
          bcd_o <= shift_reg[11:8];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign digit_next = (ref_cnt == REF_MAX) ? digit + 2'd1 : digit;
  assign blank_h    = BLANK_LEADING && (bcd_h == 4'd0);
  assign blank_t    = blank_h && (bcd_t == 4'd0);
  assign an_next    = ~(4'b0001 << digit_next);

  always_comb begin
    seg_next = 7'h7F;
    case (digit_next)
      2'd0:    seg_next = decode(bcd_o);
      2'd1:    seg_next = blank_t ? 7'h7F : decode(bcd_t);
      2'd2:    seg_next = blank_h ? 7'h7F : decode(bcd_h);
      default: seg_next = 7'h7F;
    endcase
  end

  // an and seg load together from digit_next, so a digit never shows its neighbour's pattern.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_cnt <= '0;
      digit   <= '0;
      an      <= 4'b1110;
      seg     <= 7'b1000000;
    end else begin
      ref_cnt <= (ref_cnt == REF_MAX) ? '0 : ref_cnt + 1'b1;
      digit   <= digit_next;
      an      <= an_next;
      seg     <= seg_next;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver: vector table, corner sequences,
// and randomized counts compared every cycle against a behavioural model.
module tb_seg_display_driver;

  localparam int RD = 4;

  logic       clk;
  logic       reset;
  logic [7:0] count;
  logic [3:0] an_b, an_u;
  logic [6:0] seg_b, seg_u;
  logic       dp_b, dp_u;
  logic       chk_en;

  int n_cmp = 0;
  int n_bad = 0;

  seg_display_driver #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b1)) dut_b (
    .clk(clk), .reset(reset), .count(count), .an(an_b), .seg(seg_b), .dp(dp_b));
  seg_display_driver #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b0)) dut_u (
    .clk(clk), .reset(reset), .count(count), .an(an_u), .seg(seg_u), .dp(dp_u));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] pat(input int n);
    case (n)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int d, input int v, input bit blank);
    int h, t, o;
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    case (d)
      0: return pat(o);
      1: return (blank && h == 0 && t == 0) ? 7'h7F : pat(t);
      2: return (blank && h == 0) ? 7'h7F : pat(h);
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int dig(input int k);
    return (k / RD) % 4;
  endfunction

  // Model: a conversion takes 10 edges from sampling to visible value; the
  // display slot is a pure function of edges since reset.
  int         m_k, m_timer, m_val, m_pend;
  logic [7:0] m_last;
  logic [3:0] m_an;
  logic [6:0] m_seg_b, m_seg_u;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_k <= 0; m_timer <= 0; m_val <= 0; m_pend <= 0; m_last <= 8'd0;
      m_an <= 4'b1110; m_seg_b <= 7'b1000000; m_seg_u <= 7'b1000000;
    end else begin
      m_k     <= m_k + 1;
      m_an    <= ~(4'b0001 << dig(m_k + 1));
      m_seg_b <= exp_seg(dig(m_k + 1), m_val, 1'b1);
      m_seg_u <= exp_seg(dig(m_k + 1), m_val, 1'b0);
      if (m_timer == 0) begin
        if (count != m_last) begin
          m_last <= count; m_pend <= int'(count); m_timer <= 9;
        end
      end else begin
        m_timer <= m_timer - 1;
        if (m_timer == 1) m_val <= m_pend;
      end
    end
  end

  function automatic int bcd_val_b();
    return int'(dut_b.bcd_h) * 100 + int'(dut_b.bcd_t) * 10 + int'(dut_b.bcd_o);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_blank", {20'd0, an_b, seg_b, dp_b}, {20'd0, m_an, m_seg_b, 1'b1});
      check("out_full",  {20'd0, an_u, seg_u, dp_u}, {20'd0, m_an, m_seg_u, 1'b1});
      check("bcd_model", bcd_val_b(), m_val);
    end
  end

  task automatic check_bcd(input string name, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    check(name, {20'd0, dut_b.bcd_h, dut_b.bcd_t, dut_b.bcd_o}, {20'd0, h, t, o});
  endtask

  // Watches one full frame and checks each digit's pattern by its anode.
  task automatic frame_check(input string name, input bit full,
                             input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
    logic [3:0] seen, a;
    logic [6:0] s;
    logic [31:0] e;
    seen = 4'h0;
    for (int i = 0; i < 4 * RD; i++) begin
      @(negedge clk);
      a = full ? an_u : an_b;
      s = full ? seg_u : seg_b;
      case (a)
        4'b1110: e = {25'd0, e0};
        4'b1101: e = {25'd0, e1};
        4'b1011: e = {25'd0, e2};
        4'b0111: e = {25'd0, e3};
        default: e = 32'hFFFF;
      endcase
      check(name, {25'd0, s}, e);
      seen = seen | ~a;
    end
    check({name, "_anodes"}, {28'd0, seen}, 32'hF);
  endtask

  typedef struct {
    logic [7:0] cnt;
    logic [3:0] h, t, o;
  } vec_t;
  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'd255, 4'd2, 4'd5, 4'd5};
    vecs[1] = '{8'd0,   4'd0, 4'd0, 4'd0};
    vecs[2] = '{8'd7,   4'd0, 4'd0, 4'd7};
    vecs[3] = '{8'd10,  4'd0, 4'd1, 4'd0};
    vecs[4] = '{8'd99,  4'd0, 4'd9, 4'd9};
    vecs[5] = '{8'd100, 4'd1, 4'd0, 4'd0};
    vecs[6] = '{8'd128, 4'd1, 4'd2, 4'd8};
    vecs[7] = '{8'd200, 4'd2, 4'd0, 4'd0};
    vecs[8] = '{8'd59,  4'd0, 4'd5, 4'd9};
    vecs[9] = '{8'd1,   4'd0, 4'd0, 4'd1};

    chk_en = 1'b0;
    count  = 8'd0;
    reset  = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_an",  {28'd0, an_b}, 32'hE);
    check("rst_seg", {25'd0, seg_b}, 32'h40);
    check("rst_dp",  {31'd0, dp_b}, 32'h1);
    check_bcd("rst_bcd", 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    reset  = 1'b1;
    chk_en = 1'b1;
    repeat (20) @(negedge clk);
    check_bcd("idle_zero", 4'd0, 4'd0, 4'd0);

    for (int i = 0; i < 10; i++) begin
      count = vecs[i].cnt;
      repeat (12) @(negedge clk);
      check_bcd($sformatf("vec_%0d", vecs[i].cnt), vecs[i].h, vecs[i].t, vecs[i].o);
    end

    count = 8'd255;
    repeat (12) @(negedge clk);
    frame_check("frame255", 1'b0, 7'b0010010, 7'b0010010, 7'b0100100, 7'b1111111);

    count = 8'd7;
    repeat (12) @(negedge clk);
    frame_check("blank7", 1'b0, 7'b1111000, 7'b1111111, 7'b1111111, 7'b1111111);
    frame_check("noblank7", 1'b1, 7'b1111000, 7'b1000000, 7'b1000000, 7'b1111111);

    // Change mid-conversion: 99 finishes first, 100 follows.
    count = 8'd99;
    repeat (3) @(negedge clk);
    count = 8'd100;
    repeat (6) @(negedge clk);
    check_bcd("mid_before", 4'd0, 4'd0, 4'd7);
    @(negedge clk);
    check_bcd("mid_first", 4'd0, 4'd9, 4'd9);
    repeat (9) @(negedge clk);
    check_bcd("mid_hold", 4'd0, 4'd9, 4'd9);
    @(negedge clk);
    check_bcd("mid_second", 4'd1, 4'd0, 4'd0);

    // Reset in the middle of a conversion.
    count = 8'd128;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_an",  {28'd0, an_u}, 32'hE);
    check("midrst_seg", {25'd0, seg_u}, 32'h40);
    check("midrst_dp",  {31'd0, dp_u}, 32'h1);
    check_bcd("midrst_bcd", 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (9) @(negedge clk);
    check_bcd("postrst_busy", 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    check_bcd("postrst_conv", 4'd1, 4'd2, 4'd8);

    for (int v = 0; v < 256; v++) begin
      count = 8'(v);
      repeat (10) @(negedge clk);
      check("sweep_val", bcd_val_b(), v);
      check("sweep_nib", {31'd0, (dut_b.bcd_h <= 4'd2 && dut_b.bcd_t <= 4'd9 && dut_b.bcd_o <= 4'd9)}, 32'd1);
    end

    for (int i = 0; i < 200; i++) begin
      count = 8'($urandom_range(0, 255));
      repeat ($urandom_range(1, 14)) @(negedge clk);
    end
    repeat (2 * 4 * RD) @(negedge clk);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
